// File: rtl/frv_bus_fairness_pkg.sv
// Shared types, defaults and width helper for the bus fairness monitor.
package frv_bus_fairness_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StStalled = 2'd2
  } chan_state_e;

  localparam int unsigned DefNch      = 2;
  localparam int unsigned DefMaxOut   = 2;
  localparam int unsigned DefReqBound = 8;
  localparam int unsigned DefRspBound = 8;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/frv_bus_fairness_chan.sv
// One channel of the fairness monitor: request FSM, outstanding counter,
// request/response stall counters, registered violation flags and sticky bit.
module frv_bus_fairness_chan
  import frv_bus_fairness_pkg::*;
#(
  parameter int unsigned MAX_OUT   = DefMaxOut,
  parameter int unsigned REQ_BOUND = DefReqBound,
  parameter int unsigned RSP_BOUND = DefRspBound,
  parameter int unsigned OW        = cnt_width(MAX_OUT)
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          clear,
  input  logic          req,
  input  logic          gnt,
  input  logic          recv,
  input  logic          ack,
  output logic [OW-1:0] outstanding,
  output logic          viol_req_stall,
  output logic          viol_rsp_stall,
  output logic          viol_overflow,
  output logic          viol_underflow,
  output logic          viol_req_drop,
  output logic          viol_sticky,
  output logic          sticky_nxt
);

  localparam int unsigned RW = cnt_width(REQ_BOUND);
  localparam int unsigned SW = cnt_width(RSP_BOUND);
  localparam logic [OW-1:0] OutMax = OW'(MAX_OUT);
  localparam logic [RW-1:0] ReqMax = RW'(REQ_BOUND);
  localparam logic [SW-1:0] RspMax = SW'(RSP_BOUND);

  chan_state_e   state_q, state_d;
  logic [OW-1:0] out_q, out_d;
  logic [RW-1:0] req_cnt_q, req_cnt_d, req_inc;
  logic [SW-1:0] rsp_cnt_q, rsp_cnt_d;
  // Flag order: {req_drop, underflow, overflow, rsp_stall, req_stall}
  logic [4:0]    viol_q, viol_d;
  logic          sticky_q, sticky_d;
  logic          accept, retire;

  assign accept  = req & gnt;
  assign retire  = recv & ack;
  assign req_inc = req_cnt_q + RW'(1);

  always_comb begin
    out_d     = out_q;
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    viol_d    = '0;

    if (accept && !retire) begin
      if (out_q == OutMax) viol_d[2] = 1'b1;
      else                 out_d = out_q + OW'(1);
    end else if (retire && !accept) begin
      if (out_q == '0) viol_d[3] = 1'b1;
      else             out_d = out_q - OW'(1);
    end

    unique case (state_q)
      StIdle, StWait: begin
        if (accept) begin
          state_d   = StIdle;
          req_cnt_d = '0;
        end else if (!req) begin
          viol_d[4] = (state_q == StWait);
          state_d   = StIdle;
          req_cnt_d = '0;
        end else begin
          req_cnt_d = req_inc;
          if (req_inc >= ReqMax) begin
            state_d   = StStalled;
            viol_d[0] = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StStalled: begin
        if (gnt || !req) begin
          state_d   = StIdle;
          req_cnt_d = '0;
        end else begin
          viol_d[0] = 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        req_cnt_d = '0;
      end
    endcase

    if (retire || out_q == '0) rsp_cnt_d = '0;
    else if (rsp_cnt_q != RspMax) rsp_cnt_d = rsp_cnt_q + SW'(1);
    viol_d[1] = (rsp_cnt_d >= RspMax);

    sticky_d = sticky_q | (|viol_d);

    // Clear keeps the outstanding count but wipes everything else.
    if (clear) begin
      state_d   = StIdle;
      req_cnt_d = '0;
      rsp_cnt_d = '0;
      viol_d    = '0;
      sticky_d  = 1'b0;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= StIdle;
      out_q     <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      viol_q    <= '0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      viol_q    <= viol_d;
      sticky_q  <= sticky_d;
    end
  end

  assign outstanding    = out_q;
  assign viol_req_stall = viol_q[0];
  assign viol_rsp_stall = viol_q[1];
  assign viol_overflow  = viol_q[2];
  assign viol_underflow = viol_q[3];
  assign viol_req_drop  = viol_q[4];
  assign viol_sticky    = sticky_q;
  assign sticky_nxt     = sticky_d;

endmodule

// File: rtl/frv_bus_fairness_mon.sv
// N-channel req/gnt/recv/ack fairness and protocol monitor with a global
// registered fair_ok summary.
module frv_bus_fairness_mon
  import frv_bus_fairness_pkg::*;
#(
  parameter int unsigned NCH       = DefNch,
  parameter int unsigned MAX_OUT   = DefMaxOut,
  parameter int unsigned REQ_BOUND = DefReqBound,
  parameter int unsigned RSP_BOUND = DefRspBound,
  parameter int unsigned OW        = cnt_width(MAX_OUT)
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              clear,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_gnt,
  input  logic [NCH-1:0]    ch_recv,
  input  logic [NCH-1:0]    ch_ack,
  input  logic [NCH-1:0]    ch_error,
  output logic [NCH*OW-1:0] outstanding,
  output logic [NCH-1:0]    viol_req_stall,
  output logic [NCH-1:0]    viol_rsp_stall,
  output logic [NCH-1:0]    viol_overflow,
  output logic [NCH-1:0]    viol_underflow,
  output logic [NCH-1:0]    viol_req_drop,
  output logic [NCH-1:0]    viol_sticky,
  output logic              fair_ok
);

  logic [NCH-1:0] sticky_nxt;
  logic           fair_ok_q;
  // Error responses retire exactly like clean ones, so ch_error is observed only.
  logic           error_unused;

  assign error_unused = ^ch_error;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    frv_bus_fairness_chan #(
      .MAX_OUT  (MAX_OUT),
      .REQ_BOUND(REQ_BOUND),
      .RSP_BOUND(RSP_BOUND),
      .OW       (OW)
    ) u_chan (
      .g_clk         (g_clk),
      .g_resetn      (g_resetn),
      .clear         (clear),
      .req           (ch_req[i]),
      .gnt           (ch_gnt[i]),
      .recv          (ch_recv[i]),
      .ack           (ch_ack[i]),
      .outstanding   (outstanding[i*OW +: OW]),
      .viol_req_stall(viol_req_stall[i]),
      .viol_rsp_stall(viol_rsp_stall[i]),
      .viol_overflow (viol_overflow[i]),
      .viol_underflow(viol_underflow[i]),
      .viol_req_drop (viol_req_drop[i]),
      .viol_sticky   (viol_sticky[i]),
      .sticky_nxt    (sticky_nxt[i])
    );
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) fair_ok_q <= 1'b1;
    else           fair_ok_q <= ~|sticky_nxt;
  end

  assign fair_ok = fair_ok_q;

endmodule

// File: tb/tb_frv_bus_fairness_mon.sv
// Directed bench for frv_bus_fairness_mon with NCH=2, MAX_OUT=2, bounds of 4.
module tb_frv_bus_fairness_mon;

  localparam int unsigned NCH = 2;
  localparam int unsigned OW  = 2;

  logic            g_clk = 1'b0;
  logic            g_resetn = 1'b0;
  logic            clear = 1'b0;
  logic [NCH-1:0]  ch_req = '0, ch_gnt = '0, ch_recv = '0, ch_ack = '0, ch_error = '0;
  logic [NCH*OW-1:0] outstanding;
  logic [NCH-1:0]  viol_req_stall, viol_rsp_stall, viol_overflow, viol_underflow;
  logic [NCH-1:0]  viol_req_drop, viol_sticky;
  logic            fair_ok;
  logic [11:0]     all_viol;

  int checks = 0;
  int errors = 0;

  assign all_viol = {viol_req_stall, viol_rsp_stall, viol_overflow, viol_underflow,
                     viol_req_drop, viol_sticky};

  frv_bus_fairness_mon #(
    .NCH(2), .MAX_OUT(2), .REQ_BOUND(4), .RSP_BOUND(4), .OW(2)
  ) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .clear(clear),
    .ch_req(ch_req), .ch_gnt(ch_gnt), .ch_recv(ch_recv), .ch_ack(ch_ack),
    .ch_error(ch_error), .outstanding(outstanding),
    .viol_req_stall(viol_req_stall), .viol_rsp_stall(viol_rsp_stall),
    .viol_overflow(viol_overflow), .viol_underflow(viol_underflow),
    .viol_req_drop(viol_req_drop), .viol_sticky(viol_sticky), .fair_ok(fair_ok)
  );

  always #5 g_clk = ~g_clk;

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle();
    ch_req = '0; ch_gnt = '0; ch_recv = '0; ch_ack = '0; ch_error = '0; clear = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    idle();
    tick();
    tick();
    checks++;
    if (outstanding !== 4'h0 || all_viol !== 12'h000 || fair_ok !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got out=%h viol=%h ok=%b want out=0 viol=000 ok=1",
               outstanding, all_viol, fair_ok);
    end
    g_resetn = 1'b1;
    tick();
  endtask

  task automatic test_outstanding();
    logic [3:0] exp_out [4];
    exp_out[0] = 4'h1; exp_out[1] = 4'h2; exp_out[2] = 4'h1; exp_out[3] = 4'h0;
    for (int k = 0; k < 4; k++) begin
      idle();
      if (k < 2) begin ch_req = 2'b01; ch_gnt = 2'b01; end
      else begin ch_recv = 2'b01; ch_ack = 2'b01; end
      tick();
      checks++;
      if (outstanding !== exp_out[k]) begin
        errors++;
        $display("FAIL outstanding_seq%0d got %h want %h", k, outstanding, exp_out[k]);
      end
    end
    idle();
    checks++;
    if (all_viol !== 12'h000 || fair_ok !== 1'b1) begin
      errors++;
      $display("FAIL outstanding_noviol got viol=%h ok=%b want 000/1", all_viol, fair_ok);
    end
  endtask

  task automatic test_req_stall();
    idle();
    ch_req = 2'b10;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (viol_req_stall !== ((k >= 4) ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL req_stall_edge%0d got %b want %b", k, viol_req_stall,
                 (k >= 4) ? 2'b10 : 2'b00);
      end
    end
    ch_gnt = 2'b10;
    tick();
    checks++;
    if (viol_req_stall !== 2'b00 || viol_sticky !== 2'b10 || fair_ok !== 1'b0) begin
      errors++;
      $display("FAIL req_stall_gnt got stall=%b sticky=%b ok=%b want 00/10/0",
               viol_req_stall, viol_sticky, fair_ok);
    end
    idle();
    ch_recv = 2'b10; ch_ack = 2'b10;
    tick();
    do_clear();
  endtask

  task automatic test_overflow();
    idle();
    ch_req = 2'b01; ch_gnt = 2'b01;
    tick();
    tick();
    tick();
    checks++;
    if (viol_overflow !== 2'b01 || outstanding !== 4'h2) begin
      errors++;
      $display("FAIL overflow_pulse got ovf=%b out=%h want 01/2", viol_overflow, outstanding);
    end
    idle();
    tick();
    checks++;
    if (viol_overflow !== 2'b00) begin
      errors++;
      $display("FAIL overflow_clears got %b want 00", viol_overflow);
    end
    ch_req = 2'b01; ch_gnt = 2'b01; ch_recv = 2'b01; ch_ack = 2'b01;
    tick();
    checks++;
    if (outstanding !== 4'h2 || viol_overflow !== 2'b00 || viol_underflow !== 2'b00 ||
        viol_rsp_stall !== 2'b00) begin
      errors++;
      $display("FAIL overflow_simul got out=%h ovf=%b unf=%b rsp=%b want 2/00/00/00",
               outstanding, viol_overflow, viol_underflow, viol_rsp_stall);
    end
    idle();
    ch_recv = 2'b01; ch_ack = 2'b01;
    tick();
    tick();
    checks++;
    if (outstanding !== 4'h0) begin
      errors++;
      $display("FAIL overflow_drain got %h want 0", outstanding);
    end
    do_clear();
  endtask

  task automatic test_underflow_drop();
    idle();
    ch_recv = 2'b10; ch_ack = 2'b10;
    tick();
    checks++;
    if (viol_underflow !== 2'b10 || outstanding !== 4'h0) begin
      errors++;
      $display("FAIL underflow_pulse got unf=%b out=%h want 10/0", viol_underflow, outstanding);
    end
    idle();
    tick();
    checks++;
    if (viol_underflow !== 2'b00) begin
      errors++;
      $display("FAIL underflow_clears got %b want 00", viol_underflow);
    end
    ch_req = 2'b10;
    tick();
    tick();
    ch_req = 2'b00;
    tick();
    checks++;
    if (viol_req_drop !== 2'b10 || viol_req_stall !== 2'b00) begin
      errors++;
      $display("FAIL req_drop_pulse got drop=%b stall=%b want 10/00", viol_req_drop,
               viol_req_stall);
    end
    tick();
    checks++;
    if (viol_req_drop !== 2'b00) begin
      errors++;
      $display("FAIL req_drop_clears got %b want 00", viol_req_drop);
    end
    do_clear();
  endtask

  task automatic test_error();
    idle();
    ch_req = 2'b01; ch_gnt = 2'b01;
    tick();
    idle();
    ch_recv = 2'b01; ch_error = 2'b01;
    tick();
    checks++;
    if (outstanding !== 4'h1) begin
      errors++;
      $display("FAIL error_no_ack got %h want 1", outstanding);
    end
    ch_ack = 2'b01;
    tick();
    idle();
    checks++;
    if (outstanding !== 4'h0 || all_viol !== 12'h000) begin
      errors++;
      $display("FAIL error_retire got out=%h viol=%h want 0/000", outstanding, all_viol);
    end
  endtask

  task automatic test_rsp_stall_clear();
    idle();
    ch_req = 2'b01; ch_gnt = 2'b01;
    tick();
    idle();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (viol_rsp_stall !== ((k == 4) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL rsp_stall_cyc%0d got %b want %b", k, viol_rsp_stall,
                 (k == 4) ? 2'b01 : 2'b00);
      end
    end
    ch_recv = 2'b01; ch_ack = 2'b01;
    tick();
    idle();
    checks++;
    if (outstanding !== 4'h0 || viol_rsp_stall !== 2'b00 || viol_sticky !== 2'b01 ||
        fair_ok !== 1'b0) begin
      errors++;
      $display("FAIL rsp_stall_retire got out=%h rsp=%b sticky=%b ok=%b want 0/00/01/0",
               outstanding, viol_rsp_stall, viol_sticky, fair_ok);
    end
    // Clear with ch0 outstanding=1 and a would-be ch1 underflow in the same cycle.
    ch_req = 2'b01; ch_gnt = 2'b01;
    tick();
    idle();
    clear = 1'b1; ch_recv = 2'b10; ch_ack = 2'b10;
    tick();
    idle();
    checks++;
    if (viol_sticky !== 2'b00 || fair_ok !== 1'b1 || viol_underflow !== 2'b00 ||
        outstanding !== 4'h1) begin
      errors++;
      $display("FAIL clear_effect got sticky=%b ok=%b unf=%b out=%h want 00/1/00/1",
               viol_sticky, fair_ok, viol_underflow, outstanding);
    end
    ch_recv = 2'b01; ch_ack = 2'b01;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    ch_req = 2'b11; ch_gnt = 2'b01;
    tick();
    tick();
    tick();
    checks++;
    if (outstanding !== 4'h2 || viol_overflow !== 2'b01 || fair_ok !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset got out=%h ovf=%b ok=%b want 2/01/0", outstanding,
               viol_overflow, fair_ok);
    end
    #3;
    g_resetn = 1'b0;
    #1;
    checks++;
    if (outstanding !== 4'h0 || all_viol !== 12'h000 || fair_ok !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got out=%h viol=%h ok=%b want 0/000/1", outstanding,
               all_viol, fair_ok);
    end
    idle();
    tick();
    g_resetn = 1'b1;
    ch_recv = 2'b01; ch_ack = 2'b01;
    tick();
    idle();
    checks++;
    if (viol_underflow !== 2'b01 || outstanding !== 4'h0) begin
      errors++;
      $display("FAIL post_reset_underflow got unf=%b out=%h want 01/0", viol_underflow,
               outstanding);
    end
  endtask

  initial begin
    test_reset();
    test_outstanding();
    test_req_stall();
    test_overflow();
    test_underflow_drop();
    test_error();
    test_rsp_stall_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
